gb_lcd_pixel_sink: RTL and testbench

// - Consumer end of the PPU pixel stream: takes {PX_OUT, PX_valid, PPU_MODE} and maps each pixel through BGP to a 2-bit shade.
// - Packs 4 shades per byte and writes a 160x144 frame into a double-buffered 2bpp framebuffer RAM (5760 B per bank).
// - Display/scan-out logic reads the completed bank; frame_done tells it when banks swap.

---
 rtl/gb_lcd_pixel_sink.sv | 120 ++++++++++++
 tb/tb_gb_lcd_pixel_sink.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_pixel_sink.sv
// PPU pixel stream sink: palette-maps pixels to 2-bit shades, packs four per byte and
// writes a 160x144 frame into one bank of a double-buffered 2bpp framebuffer.
module gb_lcd_pixel_sink #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int USE_PAL  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  px_in,
  input  logic        px_valid,
  input  logic [1:0]  ppu_mode,
  input  logic [7:0]  bgp,
  output logic        fb_we,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        wr_bank,
  output logic        frame_done,
  output logic        err_short,
  output logic        err_long
);

  localparam logic [1:0]  M_HBLANK  = 2'd0;
  localparam logic [1:0]  M_VBLANK  = 2'd1;
  localparam logic [1:0]  M_SCAN    = 2'd2;
  localparam logic [1:0]  M_DRAW    = 2'd3;
  localparam logic [7:0]  X_MAX     = 8'(H_PIXELS);
  localparam logic [7:0]  Y_FULL    = 8'(V_LINES);
  localparam logic [12:0] LINE_STEP = 13'(H_PIXELS / 4);

  typedef enum logic [1:0] {SYNC, WAIT, ACTIVE} state_t;

  state_t      state;
  logic [1:0]  prev_mode;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [12:0] line_base;
  logic [5:0]  pack;

  logic [1:0]  pal_shade;
  logic [1:0]  shade;
  logic        accept;
  logic        in_range;
  logic        line_end;

  assign pal_shade = bgp[{px_in, 1'b0} +: 2];
  assign shade     = (USE_PAL != 0) ? pal_shade : px_in;
  assign accept    = (state == ACTIVE) && px_valid && (ppu_mode == M_DRAW);
  assign in_range  = (x < X_MAX);
  // A line ends on the DRAW->HBLANK edge, seen against last cycle's mode.
  assign line_end  = (state == ACTIVE) && (prev_mode == M_DRAW) && (ppu_mode == M_HBLANK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      prev_mode  <= M_HBLANK;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      pack       <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      prev_mode  <= ppu_mode;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        SYNC: begin
          if (ppu_mode == M_VBLANK) state <= WAIT;
        end
        WAIT: begin
          x         <= '0;
          y         <= '0;
          line_base <= '0;
          pack      <= '0;
          if (ppu_mode == M_SCAN) state <= ACTIVE;
        end
        ACTIVE: begin
          if (accept) begin
            if (in_range) begin
              pack <= {pack[3:0], shade};
              x    <= x + 8'd1;
              if (x[1:0] == 2'd3) begin
                fb_we    <= 1'b1;
                fb_wdata <= {pack, shade};
                fb_addr  <= {wr_bank, line_base + 13'(x[7:2])};
              end
            end else begin
              err_long <= 1'b1;
            end
          end
          if (line_end) begin
            // Partial trailing group is simply dropped with the pack register.
            if ((x != 8'd0) && in_range) err_short <= 1'b1;
            x         <= '0;
            y         <= y + 8'd1;
            line_base <= line_base + LINE_STEP;
            pack      <= '0;
          end
          if (ppu_mode == M_VBLANK) begin
            state <= WAIT;
            if (y == Y_FULL) begin
              wr_bank    <= ~wr_bank;
              frame_done <= 1'b1;
            end else begin
              err_long <= 1'b1;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_lcd_pixel_sink.sv
// Randomized directed bench for gb_lcd_pixel_sink: expected framebuffer writes come from
// a per-line model (shade list -> packed bytes at bank/line/byte addresses).
module tb_gb_lcd_pixel_sink;

  localparam logic [1:0] HB = 2'd0, VB = 2'd1, SC = 2'd2, DR = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic [7:0]  bgp;

  logic        a_fb_we, a_wr_bank, a_frame_done, a_err_short, a_err_long;
  logic [13:0] a_fb_addr;
  logic [7:0]  a_fb_wdata;
  logic        b_fb_we, b_wr_bank, b_frame_done, b_err_short, b_err_long;
  logic [13:0] b_fb_addr;
  logic [7:0]  b_fb_wdata;

  gb_lcd_pixel_sink #(.H_PIXELS(160), .V_LINES(144), .USE_PAL(1)) dut_a (
    .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid), .ppu_mode(ppu_mode), .bgp(bgp),
    .fb_we(a_fb_we), .fb_addr(a_fb_addr), .fb_wdata(a_fb_wdata), .wr_bank(a_wr_bank),
    .frame_done(a_frame_done), .err_short(a_err_short), .err_long(a_err_long));

  gb_lcd_pixel_sink #(.H_PIXELS(160), .V_LINES(144), .USE_PAL(0)) dut_b (
    .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid), .ppu_mode(ppu_mode), .bgp(bgp),
    .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_wdata(b_fb_wdata), .wr_bank(b_wr_bank),
    .frame_done(b_frame_done), .err_short(b_err_short), .err_long(b_err_long));

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [21:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  int          fd_a = 0;
  int          nwr = 0;
  logic [13:0] last_addr = '0;

  // Model state: bank being written, lines completed in the frame, expected flags.
  logic m_bank = 1'b0;
  int   m_line = 0;
  int   exp_fd = 0;

  always @(negedge clk) begin
    if (a_fb_we) begin
      obs_a.push_back({a_fb_addr, a_fb_wdata});
      last_addr = a_fb_addr;
      nwr++;
    end
    if (b_fb_we) obs_b.push_back({b_fb_addr, b_fb_wdata});
    if (a_frame_done) fd_a++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick(input logic [1:0] m, input logic v, input logic [1:0] p);
    @(negedge clk);
    ppu_mode = m;
    px_valid = v;
    px_in    = p;
  endtask

  task automatic cmp_q(input string tag, input logic [21:0] obs[$], input logic [21:0] expq[$]);
    int bad;
    bad = -1;
    chk({tag, " count"}, obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++)
      if (obs[i] !== expq[i]) begin bad = i; break; end
    checks++;
    assert (bad == -1) else begin
      errs++;
      $error("FAIL %s data: idx %0d observed %h expected %h", tag, bad, obs[bad], expq[bad]);
    end
  endtask

  task automatic check_writes(input string tag);
    #1;
    cmp_q({tag, " pal"}, obs_a, exp_a);
    cmp_q({tag, " raw"}, obs_b, exp_b);
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  // pat: 0 = repeating 0,1,2,3; 1 = all zero; 2 = random.
  task automatic run_line(input int n, input int pat, input bit rnd_bgp, input bit do_end);
    logic [1:0] sa[$], sb[$];
    logic [1:0] p;
    bit v;
    int i, ngrp;
    logic [12:0] off;
    tick(SC, 1'($urandom % 2), 2'($urandom % 4));
    tick(SC, 1'($urandom % 2), 2'($urandom % 4));
    i = 0;
    while (i < n) begin
      v = ($urandom % 8) != 0;
      p = (pat == 0) ? 2'(i % 4) : (pat == 1) ? 2'd0 : 2'($urandom % 4);
      @(negedge clk);
      if (rnd_bgp) bgp = 8'($urandom);
      ppu_mode = DR;
      px_valid = v;
      px_in    = p;
      if (v) begin
        sa.push_back(bgp[2*p +: 2]);
        sb.push_back(p);
        i++;
      end
    end
    tick(DR, 1'b0, 2'd0);
    if (do_end) repeat (3) tick(HB, 1'($urandom % 2), 2'($urandom % 4));
    ngrp = ((n < 160) ? n : 160) / 4;
    for (int k = 0; k < ngrp; k++) begin
      off = 13'(m_line * 40 + k);
      exp_a.push_back({m_bank, off, sa[4*k], sa[4*k+1], sa[4*k+2], sa[4*k+3]});
      exp_b.push_back({m_bank, off, sb[4*k], sb[4*k+1], sb[4*k+2], sb[4*k+3]});
    end
    if (do_end) m_line++;
  endtask

  task automatic vblank(output bit el);
    repeat (4) tick(VB, 1'($urandom % 2), 2'($urandom % 4));
    el = 1'b0;
    if (m_line == 144) begin
      m_bank = ~m_bank;
      exp_fd++;
    end else begin
      el = 1'b1;
    end
    m_line = 0;
    #1;
  endtask

  initial begin
    bit el;
    rst = 1'b1; px_in = 2'd0; px_valid = 1'b0; ppu_mode = HB; bgp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst fb_we", a_fb_we, 0);
    chk("rst fb_addr", a_fb_addr, 0);
    chk("rst fb_wdata", a_fb_wdata, 0);
    chk("rst wr_bank", a_wr_bank, 0);
    chk("rst frame_done", a_frame_done, 0);
    chk("rst err_short", a_err_short, 0);
    chk("rst err_long", a_err_long, 0);
    rst = 1'b0;

    // Pixels before the first VBLANK are ignored.
    repeat (3) tick(SC, 1'b1, 2'd3);
    repeat (12) tick(DR, 1'b1, 2'($urandom % 4));
    repeat (2) tick(HB, 1'b1, 2'd1);
    check_writes("sync");
    repeat (3) tick(VB, 1'b0, 2'd0);

    // Frame 0: first line 0,1,2,3 with E4, then 143 random lines.
    nwr = 0;
    bgp = 8'hE4;
    run_line(160, 0, 1'b0, 1'b1);
    #1;
    chk("line0 writes", obs_a.size(), 40);
    if (obs_a.size() == 40) begin
      chk("line0 first byte", obs_a[0][7:0], 8'h1B);
      chk("line0 last addr", obs_a[39][21:8], 14'd39);
    end
    check_writes("line0");
    for (int l = 1; l < 144; l++) begin
      run_line(160, 2, 1'b1, 1'b1);
      check_writes($sformatf("f0 line%0d", l));
    end
    vblank(el);
    chk("f0 nwr", nwr, 5760);
    chk("f0 last addr", last_addr, 14'h167F);
    chk("f0 frame_done", fd_a, exp_fd);
    chk("f0 wr_bank", a_wr_bank, m_bank);
    chk("f0 err_short", a_err_short, 0);
    chk("f0 err_long", a_err_long, el);

    // Frame 1: palette 1B, short line, then too few lines.
    bgp = 8'h1B;
    run_line(160, 1, 1'b0, 1'b1);
    #1;
    if (obs_a.size() > 0 && obs_b.size() > 0) begin
      chk("bgp1B byte", obs_a[0][7:0], 8'hFF);
      chk("raw byte", obs_b[0][7:0], 8'h00);
      chk("f1 first addr", obs_a[0][21:8], 14'h2000);
    end else chk("f1 line0 writes", obs_a.size(), 40);
    check_writes("f1 line0");
    run_line(100, 2, 1'b1, 1'b1);
    #1;
    chk("short writes", obs_a.size(), 25);
    check_writes("f1 line1");
    chk("err_short", a_err_short, 1);
    chk("err_long pre", a_err_long, 0);
    run_line(160, 2, 1'b1, 1'b1);
    #1;
    if (obs_a.size() > 0) chk("after short addr", obs_a[0][21:8], 14'h2000 + 14'd80);
    check_writes("f1 line2");
    vblank(el);
    chk("f1 frame_done", fd_a, exp_fd);
    chk("f1 wr_bank", a_wr_bank, m_bank);
    chk("f1 err_long", a_err_long, el);

    // Frame 2: reset in the middle of line 3.
    for (int l = 0; l < 3; l++) begin
      run_line(160, 2, 1'b1, 1'b1);
      check_writes($sformatf("f2 line%0d", l));
    end
    run_line(50, 2, 1'b1, 1'b0);
    check_writes("f2 line3 part");
    @(negedge clk);
    rst = 1'b1; ppu_mode = DR; px_valid = 1'b1; px_in = 2'd2;
    @(negedge clk);
    chk("mid rst fb_we", a_fb_we, 0);
    chk("mid rst wr_bank", a_wr_bank, 0);
    chk("mid rst err_long", a_err_long, 0);
    chk("mid rst err_short", a_err_short, 0);
    rst = 1'b0;
    m_bank = 1'b0; m_line = 0;
    repeat (2) tick(SC, 1'b1, 2'd1);
    repeat (20) tick(DR, 1'b1, 2'($urandom % 4));
    repeat (2) tick(HB, 1'b0, 2'd0);
    check_writes("post rst ignore");
    repeat (3) tick(VB, 1'b0, 2'd0);

    // After resync: overlong line, empty line, then a full line at base 80.
    run_line(162, 2, 1'b1, 1'b1);
    #1;
    chk("long writes", obs_a.size(), 40);
    check_writes("r line0");
    chk("err_long long", a_err_long, 1);
    run_line(0, 2, 1'b0, 1'b1);
    run_line(160, 2, 1'b1, 1'b1);
    check_writes("r line2");
    chk("empty line no err_short", a_err_short, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
